controle_jogo: RTL and testbench

Game-flow controller for the ship-vs-enemy VGA game. Sequences the projectile (bola) instances and the screen block: start, play, pause, hit-recovery and game-over states. Issues the per-frame movement enable and rate-limited fire pulses, and owns score, lives and the session high score. Sits between the key debouncer, the bola instances and the tela renderer.

---
 rtl/controle_jogo.sv | 189 ++++++++++++++++++
 tb/tb_controle_jogo.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/controle_jogo.sv
// Game-flow controller for the ship-vs-enemy VGA game.
// This block sequences the game states and owns the score, the lives and the
// session high score. It also issues the per-frame movement enable and the
// rate-limited fire pulse.
// Optional build macro VIDA_EXTRA_EN: when defined, an extra life is granted
// each time the low nibble of the score wraps to zero.
//
// state   | meaning
// --------+-----------------------------------------------------------
// INICIO  | waiting for disparo/reiniciarJogo to start a game
// JOGANDO | game running: movement, firing, scoring, life loss
// PAUSADO | pause switch set; everything frozen
// ACERTO  | ship was hit; frozen for FRAMES_ACERTO frames
// PERDEU  | no lives left; only a restart leaves this state
module controle_jogo #(
  parameter int VIDAS_INICIAIS = 3,
  parameter int LARGURA_PLACAR = 8,
  parameter int FRAMES_RECARGA = 15,
  parameter int FRAMES_ACERTO  = 30,
  parameter int DIV_MOVIMENTO  = 1
) (
  input  logic                      CLOCK_50,
  input  logic                      reset,
  input  logic                      fim_quadro,
  input  logic                      pausa,
  input  logic                      reiniciarJogo,
  input  logic                      disparo,
  input  logic                      atingiuInimigo,
  input  logic                      atingiuNave,
  output logic                      mover,
  output logic                      disparar,
  output logic [LARGURA_PLACAR-1:0] placar,
  output logic [LARGURA_PLACAR-1:0] placarMax,
  output logic [3:0]                vidas,
  output logic                      perdeu,
  output logic [2:0]                estado
);

  localparam int CW = (FRAMES_RECARGA < 1) ? 1 : $clog2(FRAMES_RECARGA + 1);
  localparam int AW = (FRAMES_ACERTO < 1) ? 1 : $clog2(FRAMES_ACERTO + 1);
  localparam int DW = (DIV_MOVIMENTO < 2) ? 1 : $clog2(DIV_MOVIMENTO);

  localparam logic [CW-1:0] RECARGA_INI = CW'(FRAMES_RECARGA);
  localparam logic [AW-1:0] ACERTO_INI  = AW'(FRAMES_ACERTO);
  localparam logic [DW-1:0] DIV_ULTIMO  = DW'(DIV_MOVIMENTO - 1);
  localparam logic [3:0]    VIDAS_INI   = 4'(VIDAS_INICIAIS);
  localparam logic [LARGURA_PLACAR-1:0] PLACAR_CHEIO = '1;

  typedef enum logic [2:0] {
    INICIO  = 3'd0,
    JOGANDO = 3'd1,
    PAUSADO = 3'd2,
    ACERTO  = 3'd3,
    PERDEU  = 3'd4
  } estado_t;

  estado_t                   estado_q, estado_d;
  logic [LARGURA_PLACAR-1:0] placar_d, placar_inc;
  logic [3:0]                vidas_d;
  logic [CW-1:0]             recarga_q, recarga_d;
  logic [AW-1:0]             acerto_q, acerto_d;
  logic [DW-1:0]             div_q, div_d;
  logic                      mover_d, disparar_d;
  logic                      reinicia, vida_extra;

  assign estado = estado_q;

  // Registers for the state, the counters and every output.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      estado_q  <= INICIO;
      placar    <= '0;
      placarMax <= '0;
      vidas     <= VIDAS_INI;
      recarga_q <= '0;
      acerto_q  <= '0;
      div_q     <= '0;
      mover     <= 1'b0;
      disparar  <= 1'b0;
      perdeu    <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      placar    <= placar_d;
      // The high score follows the registered score, so it lags it by one cycle.
      placarMax <= (placar > placarMax) ? placar : placarMax;
      vidas     <= vidas_d;
      recarga_q <= recarga_d;
      acerto_q  <= acerto_d;
      div_q     <= div_d;
      mover     <= mover_d;
      disparar  <= disparar_d;
      perdeu    <= (estado_d == PERDEU);
    end
  end

  // Next-state and next-value logic. Restart wins over every other event.
  always_comb begin
    estado_d   = estado_q;
    placar_d   = placar;
    vidas_d    = vidas;
    recarga_d  = recarga_q;
    acerto_d   = acerto_q;
    div_d      = div_q;
    mover_d    = 1'b0;
    disparar_d = 1'b0;
    vida_extra = 1'b0;
    placar_inc = (placar == PLACAR_CHEIO) ? placar : placar + 1'b1;
`ifdef VIDA_EXTRA_EN
    vida_extra = atingiuInimigo && (placar != PLACAR_CHEIO) && (placar_inc[3:0] == 4'd0);
`endif
    reinicia = reiniciarJogo && (estado_q != INICIO);

    if (reinicia) begin
      estado_d  = INICIO;
      placar_d  = '0;
      vidas_d   = VIDAS_INI;
      recarga_d = '0;
    end else begin
      case (estado_q)
        INICIO: begin
          // The key that starts the game never fires a shot.
          if (reiniciarJogo || disparo) begin
            estado_d  = JOGANDO;
            placar_d  = '0;
            vidas_d   = VIDAS_INI;
            recarga_d = '0;
            div_d     = '0;
          end
        end
        JOGANDO: begin
          if (pausa) begin
            estado_d = PAUSADO;
          end else begin
            if (fim_quadro) begin
              if (div_q == DIV_ULTIMO) begin
                div_d   = '0;
                mover_d = 1'b1;
              end else begin
                div_d = div_q + 1'b1;
              end
              if (recarga_q != '0) recarga_d = recarga_q - 1'b1;
            end
            // Fire only when the cooldown is already zero; a request in the
            // cycle of the last decrement is dropped, not queued.
            if (disparo && (recarga_q == '0)) begin
              disparar_d = 1'b1;
              recarga_d  = RECARGA_INI;
            end
            if (atingiuInimigo) placar_d = placar_inc;
            // An extra life in the same cycle as a hit cancels the loss and
            // the game keeps running.
            if (atingiuNave && !vida_extra) begin
              if (vidas <= 4'd1) begin
                vidas_d  = 4'd0;
                estado_d = PERDEU;
              end else begin
                vidas_d  = vidas - 1'b1;
                estado_d = ACERTO;
                acerto_d = ACERTO_INI;
              end
            end else if (vida_extra && !atingiuNave && (vidas != 4'hF)) begin
              vidas_d = vidas + 1'b1;
            end
          end
        end
        PAUSADO: begin
          if (!pausa) estado_d = JOGANDO;
        end
        ACERTO: begin
          if (!pausa && fim_quadro) begin
            if (acerto_q <= AW'(1)) begin
              acerto_d = '0;
              estado_d = JOGANDO;
            end else begin
              acerto_d = acerto_q - 1'b1;
            end
          end
        end
        PERDEU: begin
          estado_d = PERDEU;
        end
        default: begin
          estado_d = INICIO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_controle_jogo.sv
// Directed bench for controle_jogo with default parameters.
module tb_controle_jogo;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b0;
  logic       fim_quadro = 1'b0;
  logic       pausa = 1'b0;
  logic       reiniciarJogo = 1'b0;
  logic       disparo = 1'b0;
  logic       atingiuInimigo = 1'b0;
  logic       atingiuNave = 1'b0;
  logic       mover, disparar, perdeu;
  logic [7:0] placar, placarMax;
  logic [3:0] vidas;
  logic [2:0] estado;

  int n_checks = 0;
  int n_fail = 0;
  int mv;

  controle_jogo dut (
    .CLOCK_50      (CLOCK_50),
    .reset         (reset),
    .fim_quadro    (fim_quadro),
    .pausa         (pausa),
    .reiniciarJogo (reiniciarJogo),
    .disparo       (disparo),
    .atingiuInimigo(atingiuInimigo),
    .atingiuNave   (atingiuNave),
    .mover         (mover),
    .disparar      (disparar),
    .placar        (placar),
    .placarMax     (placarMax),
    .vidas         (vidas),
    .perdeu        (perdeu),
    .estado        (estado)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    logic       fq, pa, re, di, ai, an;
    logic [2:0] e_est;
    logic [7:0] e_pl;
    logic [3:0] e_vi;
    logic [7:0] e_mx;
    logic       e_mv, e_dp, e_pd;
  } vec_t;

  vec_t tab[16];

  function automatic vec_t mk(input int fq, pa, re, di, ai, an,
                              input int est, pl, vi, mx, mvv, dp, pd);
    vec_t r;
    r.fq = fq[0]; r.pa = pa[0]; r.re = re[0]; r.di = di[0];
    r.ai = ai[0]; r.an = an[0];
    r.e_est = est[2:0]; r.e_pl = pl[7:0]; r.e_vi = vi[3:0];
    r.e_mx = mx[7:0]; r.e_mv = mvv[0]; r.e_dp = dp[0]; r.e_pd = pd[0];
    return r;
  endfunction

  task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nome, act, expv);
    end
  endtask

  // One clock cycle with the given inputs; outputs are sampled 1 ns after the edge.
  task automatic tick(input logic fq, pa, re, di, ai, an);
    fim_quadro = fq; pausa = pa; reiniciarJogo = re;
    disparo = di; atingiuInimigo = ai; atingiuNave = an;
    @(posedge CLOCK_50);
    #1;
    fim_quadro = 1'b0; reiniciarJogo = 1'b0; disparo = 1'b0;
    atingiuInimigo = 1'b0; atingiuNave = 1'b0;
  endtask

  initial begin
    //             fq pa re di ai an  est pl vi mx mv dp pd
    tab[0]  = mk(0, 0, 0, 0, 0, 0,   0, 0, 3, 0, 0, 0, 0);
    tab[1]  = mk(0, 0, 1, 0, 0, 0,   1, 0, 3, 0, 0, 0, 0);
    tab[2]  = mk(1, 0, 0, 0, 0, 0,   1, 0, 3, 0, 1, 0, 0);
    tab[3]  = mk(0, 0, 0, 0, 0, 0,   1, 0, 3, 0, 0, 0, 0);
    tab[4]  = mk(1, 0, 0, 0, 0, 0,   1, 0, 3, 0, 1, 0, 0);
    tab[5]  = mk(1, 0, 0, 0, 0, 0,   1, 0, 3, 0, 1, 0, 0);
    tab[6]  = mk(0, 0, 0, 1, 0, 0,   1, 0, 3, 0, 0, 1, 0);
    tab[7]  = mk(0, 0, 0, 0, 0, 0,   1, 0, 3, 0, 0, 0, 0);
    tab[8]  = mk(0, 0, 0, 1, 0, 0,   1, 0, 3, 0, 0, 0, 0);
    tab[9]  = mk(0, 0, 0, 0, 1, 0,   1, 1, 3, 0, 0, 0, 0);
    tab[10] = mk(0, 0, 0, 0, 1, 1,   3, 2, 2, 1, 0, 0, 0);
    tab[11] = mk(0, 0, 0, 0, 1, 0,   3, 2, 2, 2, 0, 0, 0);
    tab[12] = mk(1, 1, 0, 0, 0, 0,   3, 2, 2, 2, 0, 0, 0);
    tab[13] = mk(0, 0, 1, 0, 0, 0,   0, 0, 3, 2, 0, 0, 0);
    tab[14] = mk(0, 0, 0, 1, 0, 0,   1, 0, 3, 2, 0, 0, 0);
    tab[15] = mk(0, 0, 0, 0, 0, 0,   1, 0, 3, 2, 0, 0, 0);

    // Reset values while reset is held.
    repeat (2) @(posedge CLOCK_50);
    #1;
    chk("rst estado", estado, 0);
    chk("rst vidas", vidas, 3);
    chk("rst placar", placar, 0);
    reset = 1'b1;

    for (int i = 0; i < 16; i++) begin
      tick(tab[i].fq, tab[i].pa, tab[i].re, tab[i].di, tab[i].ai, tab[i].an);
      chk($sformatf("vec%0d estado", i), estado, tab[i].e_est);
      chk($sformatf("vec%0d placar", i), placar, tab[i].e_pl);
      chk($sformatf("vec%0d vidas", i), vidas, tab[i].e_vi);
      chk($sformatf("vec%0d placarMax", i), placarMax, tab[i].e_mx);
      chk($sformatf("vec%0d mover", i), mover, tab[i].e_mv);
      chk($sformatf("vec%0d disparar", i), disparar, tab[i].e_dp);
      chk($sformatf("vec%0d perdeu", i), perdeu, tab[i].e_pd);
    end

    // Fire cooldown: 15 frames, requests dropped while it runs.
    tick(0, 0, 0, 1, 0, 0);
    chk("fire first", disparar, 1);
    mv = 0;
    repeat (5) begin tick(1, 0, 0, 0, 0, 0); mv += int'(mover); end
    tick(0, 0, 0, 1, 0, 0);
    chk("fire during cooldown", disparar, 0);
    repeat (9) begin tick(1, 0, 0, 0, 0, 0); mv += int'(mover); end
    tick(1, 0, 0, 1, 0, 0);
    mv += int'(mover);
    chk("fire on last decrement", disparar, 0);
    tick(0, 0, 0, 1, 0, 0);
    chk("fire after cooldown", disparar, 1);
    chk("mover count", mv, 15);

    // Score and high score across a restart.
    repeat (5) tick(0, 0, 0, 0, 1, 0);
    chk("score 5", placar, 5);
    tick(0, 0, 0, 0, 0, 0);
    chk("max 5", placarMax, 5);
    tick(0, 0, 1, 0, 0, 0);
    chk("restart estado", estado, 0);
    chk("restart placar", placar, 0);
    tick(0, 0, 0, 0, 0, 0);
    chk("max kept", placarMax, 5);
    tick(0, 0, 1, 0, 0, 0);
    chk("start again", estado, 1);
    repeat (2) tick(0, 0, 0, 0, 1, 0);
    tick(0, 0, 0, 0, 0, 0);
    chk("score 2", placar, 2);
    chk("max stays 5", placarMax, 5);

    // Hit recovery and game over.
    tick(0, 0, 0, 0, 0, 1);
    chk("hit vidas", vidas, 2);
    chk("hit estado", estado, 3);
    tick(0, 0, 0, 0, 1, 0);
    chk("score frozen in acerto", placar, 2);
    mv = 0;
    repeat (29) begin tick(1, 0, 0, 0, 0, 0); mv += int'(mover); end
    chk("acerto after 29", estado, 3);
    tick(1, 0, 0, 0, 0, 0);
    mv += int'(mover);
    chk("acerto after 30", estado, 1);
    chk("no mover in acerto", mv, 0);
    tick(0, 0, 0, 0, 0, 1);
    chk("second hit vidas", vidas, 1);
    repeat (30) tick(1, 0, 0, 0, 0, 0);
    chk("second recover", estado, 1);
    tick(0, 0, 0, 0, 0, 1);
    chk("last hit vidas", vidas, 0);
    chk("last hit estado", estado, 4);
    chk("perdeu high", perdeu, 1);
    tick(0, 0, 0, 1, 1, 0);
    chk("perdeu no fire", disparar, 0);
    chk("perdeu placar", placar, 2);
    chk("perdeu stays", estado, 4);
    tick(0, 0, 1, 0, 0, 0);
    chk("restart from perdeu", estado, 0);
    chk("restart perdeu low", perdeu, 0);
    chk("restart vidas", vidas, 3);

    // Pause handling.
    tick(0, 0, 1, 0, 0, 0);
    tick(0, 1, 0, 0, 1, 0);
    chk("pause estado", estado, 2);
    chk("pause precedence", placar, 0);
    tick(1, 1, 0, 1, 0, 0);
    chk("pause no mover", mover, 0);
    chk("pause no fire", disparar, 0);
    tick(0, 1, 0, 0, 0, 1);
    chk("pause ignores hit", vidas, 3);
    tick(0, 0, 0, 0, 0, 0);
    chk("unpause estado", estado, 1);
    tick(0, 0, 0, 1, 0, 0);
    chk("fire after pause", disparar, 1);

`ifdef VIDA_EXTRA_EN
    tick(0, 0, 0, 0, 0, 1);
    repeat (30) tick(1, 0, 0, 0, 0, 0);
    repeat (15) tick(0, 0, 0, 0, 1, 0);
    chk("extra pre placar", placar, 15);
    chk("extra pre vidas", vidas, 2);
    tick(0, 0, 0, 0, 1, 1);
    chk("extra placar", placar, 16);
    chk("extra vidas", vidas, 2);
    chk("extra estado", estado, 1);
`endif

    // Score saturation.
    tick(0, 0, 1, 0, 0, 0);
    tick(0, 0, 1, 0, 0, 0);
    repeat (300) tick(0, 0, 0, 0, 1, 0);
    chk("score saturates", placar, 255);

    // Asynchronous reset mid-game.
    tick(1, 0, 0, 0, 0, 0);
    chk("mover before reset", mover, 1);
    #2 reset = 1'b0;
    #1;
    chk("async estado", estado, 0);
    chk("async placar", placar, 0);
    chk("async max", placarMax, 0);
    chk("async vidas", vidas, 3);
    chk("async mover", mover, 0);
    chk("async disparar", disparar, 0);
    chk("async perdeu", perdeu, 0);
    @(posedge CLOCK_50);
    #1 reset = 1'b1;
    tick(0, 0, 0, 0, 0, 0);
    chk("after reset estado", estado, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
